// File: rtl/direct_mapped_cache.sv
// Read-only direct-mapped cache for trace-driven hit-rate studies; misses fill the whole line
// from a backing memory whose word at aligned address A holds A. 1-cycle registered outputs, no stall.
module direct_mapped_cache #(
  parameter int INDEX_BITS  = 8,
  parameter int OFFSET_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  output logic [31:0] Data_Out,
  output logic        Hit_Miss,
  output logic [31:0] rate
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << (OFFSET_BITS - 2);
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int WSEL_W   = (OFFSET_BITS > 2) ? OFFSET_BITS - 2 : 1;

  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] index;
  logic [WSEL_W-1:0]     word_sel;
  logic [31:0]           line_base;
  logic                  hit;

  assign tag       = Address[31 -: TAG_BITS];
  assign index     = Address[OFFSET_BITS +: INDEX_BITS];
  // Masking keeps the single-word-line case (OFFSET_BITS == 2) selecting word 0.
  assign word_sel  = Address[2 +: WSEL_W] & WSEL_W'(WORDS - 1);
  assign line_base = {Address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][WORDS];

  assign hit = valid_q[index] && (tag_q[index] == tag);

  logic [31:0] acc_q, acc_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] data_out_q, data_out_d;
  logic        hit_q, hit_d;
  logic [31:0] rate_q, rate_d;
  logic [39:0] rate_num, rate_quot;

  always_comb begin
    acc_d  = acc_q;
    hits_d = hits_q;
    // Both counters freeze together once the access count saturates.
    if (acc_q != 32'hFFFF_FFFF) begin
      acc_d = acc_q + 32'd1;
      if (hit) begin
        hits_d = hits_q + 32'd1;
      end
    end
    hit_d      = hit;
    data_out_d = hit ? data_q[index][word_sel] : {Address[31:2], 2'b00};
    rate_num   = {8'd0, hits_d} * 40'd100;
    rate_quot  = (acc_d == 32'd0) ? 40'd0 : rate_num / {8'd0, acc_d};
    rate_d     = rate_quot[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      acc_q      <= '0;
      hits_q     <= '0;
      data_out_q <= '0;
      hit_q      <= 1'b0;
      rate_q     <= '0;
    end else begin
      acc_q      <= acc_d;
      hits_q     <= hits_d;
      data_out_q <= data_out_d;
      hit_q      <= hit_d;
      rate_q     <= rate_d;
      if (!hit) begin
        valid_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data storage need no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!reset && !hit) begin
      tag_q[index] <= tag;
      for (int w = 0; w < WORDS; w++) begin
        data_q[index][w] <= line_base | (32'(w) << 2);
      end
    end
  end

  logic [9:0] unused_bits;
  assign unused_bits = {Address[1:0], rate_quot[39:32]};

  assign Data_Out = data_out_q;
  assign Hit_Miss = hit_q;
  assign rate     = rate_q;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Bench for direct_mapped_cache: per-cycle comparison against a line-table model, directed
// literal cases, then randomized traces with occasional mid-run resets.
module tb_direct_mapped_cache;

  localparam int IB = 8;
  localparam int OB = 4;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Data_Out;
  logic        Hit_Miss;
  logic [31:0] rate;

  int errors = 0;
  int checks = 0;

  direct_mapped_cache #(.INDEX_BITS(IB), .OFFSET_BITS(OB)) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .Data_Out (Data_Out),
    .Hit_Miss (Hit_Miss),
    .rate     (rate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: which tag each line currently holds, plus plain counts.
  bit          m_valid [1 << IB];
  logic [31:0] m_tag   [1 << IB];
  longint      m_acc, m_hits;
  logic [31:0] e_data, e_rate;
  logic        e_hit;
  bit          started = 0;
  bit          hcur;
  int          idx;
  logic [31:0] tg;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1 << IB); i++) m_valid[i] = 0;
      m_acc = 0; m_hits = 0;
      e_data = 0; e_hit = 0; e_rate = 0;
      started = 1;
    end else begin
      idx  = int'(Address[OB +: IB]);
      tg   = Address >> (IB + OB);
      hcur = m_valid[idx] && (m_tag[idx] == tg);
      if (m_acc < 64'h0000_0000_FFFF_FFFF) begin
        m_acc++;
        if (hcur) m_hits++;
      end
      if (!hcur) begin
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
      end
      e_hit  = hcur;
      e_data = {Address[31:2], 2'b00};
      e_rate = (m_acc == 0) ? 32'd0 : 32'(m_hits * 100 / m_acc);
    end
    #1;
    if (started) begin
      chk("cyc_hit", {31'd0, Hit_Miss}, {31'd0, e_hit});
      chk("cyc_data", Data_Out, e_data);
      chk("cyc_rate", rate, e_rate);
    end
  end

  task automatic cyc(input logic [31:0] a, input logic r);
    @(negedge clk);
    Address = a;
    reset   = r;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic h, input logic [31:0] d, input logic [31:0] rt);
    chk({name, "_hit"}, {31'd0, Hit_Miss}, {31'd0, h});
    chk({name, "_data"}, Data_Out, d);
    chk({name, "_rate"}, rate, rt);
  endtask

  logic [31:0] a;

  initial begin
    reset   = 1'b1;
    Address = 32'd0;
    cyc(32'd0, 1'b1);
    cyc(32'd0, 1'b1);
    lit("reset", 1'b0, 32'd0, 32'd0);

    cyc(32'h0000_0010, 1'b0); lit("first_miss", 1'b0, 32'h10, 32'd0);
    cyc(32'h0000_0014, 1'b0); lit("same_line",  1'b1, 32'h14, 32'd50);
    cyc(32'h0000_1010, 1'b0); lit("new_tag",    1'b0, 32'h1010, 32'd33);
    cyc(32'h0000_0010, 1'b0); lit("evicted",    1'b0, 32'h10, 32'd25);

    cyc(32'd0, 1'b1);
    cyc(32'h0000_ABC0, 1'b0); lit("abc0_1", 1'b0, 32'hABC0, 32'd0);
    cyc(32'h0000_ABC0, 1'b0); lit("abc0_2", 1'b1, 32'hABC0, 32'd50);
    cyc(32'h0000_ABC0, 1'b0); lit("abc0_3", 1'b1, 32'hABC0, 32'd66);
    cyc(32'h0000_ABC0, 1'b0); lit("abc0_4", 1'b1, 32'hABC0, 32'd75);
    cyc(32'h0000_0013, 1'b0); lit("low_bits", 1'b0, 32'h10, 32'd60);

    cyc(32'h0000_0020, 1'b0);
    cyc(32'h0000_0020, 1'b1); lit("mid_reset", 1'b0, 32'd0, 32'd0);
    cyc(32'h0000_0020, 1'b0); lit("after_reset", 1'b0, 32'h20, 32'd0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom();
      else a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      cyc(a, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    cyc(32'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
